// File: rtl/multicast_bus_buffered.sv
// Purpose : buffered multicast from one slave port to MASTER_NUMS PE masters; each entry goes to every master whose scanned ID equals its tag, or to all masters in broadcast mode.
// Latency : 2 cycles from push accept to master enable; one entry per cycle when every matched master is ready.
// Backpress: in_ready low only while the FIFO is full; each master handshakes on its own, so a stalled master holds only the head entry.
// Ports   : clk/rst (async active-high); in_ready, in_enable_tag_value {en,tag,value}, in_bcast (slave side);
//           master_ready, master_enable_data {en,value} (per master); set_id, id_scan_in, id_scan_out (ID scan chain);
//           busy (FIFO or head occupied); drop_count (saturating count of entries matching no master).
module multicast_bus_buffered #(
    parameter int MASTER_NUMS = 14,
    parameter int ID_LEN      = 5,
    parameter int VALUE_LEN   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    output logic                                  in_ready,
    input  logic [VALUE_LEN+ID_LEN:0]             in_enable_tag_value,
    input  logic                                  in_bcast,
    input  logic [MASTER_NUMS-1:0]                master_ready,
    output logic [MASTER_NUMS-1:0][VALUE_LEN:0]   master_enable_data,
    input  logic                                  set_id,
    input  logic [ID_LEN-1:0]                     id_scan_in,
    output logic [ID_LEN-1:0]                     id_scan_out,
    output logic                                  busy,
    output logic [15:0]                           drop_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + ID_LEN + VALUE_LEN;

    typedef enum logic {S_EMPTY, S_DELIVER} state_t;

    state_t                 state;
    logic [ENTRY_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic [ID_LEN-1:0]      id [MASTER_NUMS];
    logic [VALUE_LEN-1:0]   head_value;
    logic [MASTER_NUMS-1:0] pending;
    logic [MASTER_NUMS-1:0] match;

    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   done;
    logic                   fifo_bcast;
    logic [ID_LEN-1:0]      fifo_tag;
    logic [VALUE_LEN-1:0]   fifo_value;

    assign fifo_empty = (count == '0);
    assign in_ready   = (count < (PTR_W+1)'(FIFO_DEPTH));
    assign push       = in_enable_tag_value[ENTRY_W-1] && in_ready;

    // Every still-pending master transfers this cycle; pending is always
    // zero in S_EMPTY so done is trivially true there.
    assign done = ((pending & ~master_ready) == '0);
    assign pop  = !fifo_empty && ((state == S_EMPTY) || done);

    assign {fifo_bcast, fifo_tag, fifo_value} = fifo_mem[rd_ptr];

    // Match uses the IDs present in the load cycle; later scans never
    // touch an already-loaded head.
    always_comb begin
        match = '0;
        for (int i = 0; i < MASTER_NUMS; i++) begin
            match[i] = fifo_bcast || (id[i] == fifo_tag);
        end
    end

    // FIFO storage: stored entry is {bcast, tag, value}
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_bcast, in_enable_tag_value[ENTRY_W-2:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // ID scan chain: shifts toward id[MASTER_NUMS-1] on each set_id
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MASTER_NUMS; i++) id[i] <= '0;
        end else if (set_id) begin
            id[0] <= id_scan_in;
            for (int i = 1; i < MASTER_NUMS; i++) id[i] <= id[i-1];
        end
    end

    // Head stage. pending is cleared per master as it transfers, so it is
    // all-zero in S_EMPTY and can drive the enables directly. An all-zero
    // pending while in S_DELIVER can only come from a zero-match load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_EMPTY;
            pending    <= '0;
            head_value <= '0;
            drop_count <= '0;
        end else begin
            if (state == S_DELIVER && pending == '0 && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (pop) begin
                state      <= S_DELIVER;
                pending    <= match;
                head_value <= fifo_value;
            end else if (state == S_DELIVER) begin
                pending <= pending & ~master_ready;
                if (done) state <= S_EMPTY;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MASTER_NUMS; i++) begin
            master_enable_data[i] = {pending[i], head_value};
        end
    end

    assign busy        = !fifo_empty || (state == S_DELIVER);
    assign id_scan_out = id[MASTER_NUMS-1];

endmodule

// File: tb/tb_multicast_bus_buffered.sv
module tb_multicast_bus_buffered;

    localparam int N = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_ready;
    logic [37:0]       in_enable_tag_value = '0;
    logic              in_bcast = 1'b0;
    logic [N-1:0]      master_ready = '0;
    logic [N-1:0][32:0] master_enable_data;
    logic              set_id = 1'b0;
    logic [4:0]        id_scan_in = '0;
    logic [4:0]        id_scan_out;
    logic              busy;
    logic [15:0]       drop_count;

    int errors = 0;
    int checks = 0;

    // Reference model: scanned IDs, per-master queues of values still owed,
    // and the expected drop counter.
    logic [4:0]  m_id [N];
    logic [31:0] exp_q [N][$];
    logic [15:0] m_drops;

    always #5 clk = ~clk;

    multicast_bus_buffered #(
        .MASTER_NUMS(N), .ID_LEN(5), .VALUE_LEN(32), .FIFO_DEPTH(4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_ready            (in_ready),
        .in_enable_tag_value (in_enable_tag_value),
        .in_bcast            (in_bcast),
        .master_ready        (master_ready),
        .master_enable_data  (master_enable_data),
        .set_id              (set_id),
        .id_scan_in          (id_scan_in),
        .id_scan_out         (id_scan_out),
        .busy                (busy),
        .drop_count          (drop_count)
    );

    // Every completed handshake must hand over the next value owed to that master.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (master_enable_data[i][32] && master_ready[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL deliver_m%0d: got value %h, required no transfer", i, master_enable_data[i][31:0]);
                    end else begin
                        if (master_enable_data[i][31:0] !== exp_q[i][0]) begin
                            errors++;
                            $display("FAIL deliver_m%0d: got %h required %h", i, master_enable_data[i][31:0], exp_q[i][0]);
                        end
                        void'(exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    function automatic logic [N-1:0] en_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = master_enable_data[i][32];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_id[i] = '0;
            exp_q[i].delete();
        end
        m_drops = '0;
    endtask

    task automatic model_push(input logic [4:0] tag, input logic [31:0] val, input logic bc);
        bit any = 0;
        for (int i = 0; i < N; i++) begin
            if (bc || m_id[i] == tag) begin
                exp_q[i].push_back(val);
                any = 1;
            end
        end
        if (!any && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_id(input logic [4:0] v);
        set_id = 1'b1;
        id_scan_in = v;
        tick();
        set_id = 1'b0;
        for (int i = N-1; i > 0; i--) m_id[i] = m_id[i-1];
        m_id[0] = v;
    endtask

    // Returns one cycle after the accepting edge.
    task automatic push(input logic [4:0] tag, input logic [31:0] val, input logic bc);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_wait: in_ready stayed %b, required 1", in_ready);
        end else begin
            in_enable_tag_value = {1'b1, tag, val};
            in_bcast = bc;
            model_push(tag, val, bc);
            tick();
            in_enable_tag_value = '0;
            in_bcast = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (id_scan_out !== 5'd0) begin errors++; $display("FAIL reset_scan_out: got %0d required 0", id_scan_out); end
        checks++; if (en_vec() !== '0) begin errors++; $display("FAIL reset_enables: got %b required 0", en_vec()); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unicast();
        logic [N-1:0] exp_en = '0;
        for (int k = 0; k < N; k++) scan_id(5'(k));
        checks++; if (id_scan_out !== m_id[N-1]) begin errors++; $display("FAIL uni_scan_out: got %0d required %0d", id_scan_out, m_id[N-1]); end
        for (int i = 0; i < N; i++) if (m_id[i] == 5'd5) exp_en[i] = 1'b1;
        master_ready = '1;
        push(5'd5, 32'hA5A5A5A5, 1'b0);
        checks++; if (en_vec() !== '0) begin errors++; $display("FAIL uni_early: got %b required 0", en_vec()); end
        tick();
        checks++; if (en_vec() !== exp_en) begin errors++; $display("FAIL uni_en: got %b required %b", en_vec(), exp_en); end
        checks++; if (master_enable_data[8][31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL uni_value: got %h required a5a5a5a5", master_enable_data[8][31:0]); end
        tick();
        checks++; if (en_vec() !== '0) begin errors++; $display("FAIL uni_one_cycle: got %b required 0", en_vec()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL uni_busy: got %b required 0", busy); end
    endtask

    task automatic test_stall();
        logic [N-1:0] exp_en;
        for (int k = 0; k < N; k++) scan_id(5'd3);
        master_ready = {{(N-1){1'b1}}, 1'b0};
        push(5'd3, $urandom, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_en = (c == 1) ? {N{1'b1}} : {{(N-1){1'b0}}, 1'b1};
            checks++; if (en_vec() !== exp_en) begin errors++; $display("FAIL stall_en_c%0d: got %b required %b", c, en_vec(), exp_en); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_c%0d: got %b required 1", c, busy); end
            if (c == 5) master_ready = '1;
        end
        tick();
        checks++; if (en_vec() !== '0) begin errors++; $display("FAIL stall_release: got %b required 0", en_vec()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_bcast();
        master_ready = '1;
        push(5'd31, $urandom, 1'b1);
        tick();
        checks++; if (en_vec() !== {N{1'b1}}) begin errors++; $display("FAIL bcast_en: got %b required all ones", en_vec()); end
        tick();
        checks++; if (en_vec() !== '0) begin errors++; $display("FAIL bcast_end: got %b required 0", en_vec()); end
    endtask

    task automatic test_full();
        master_ready = '0;
        // The first entry moves into the head stage, so the FIFO itself
        // fills only after four further pushes.
        for (int k = 0; k < 5; k++) begin
            push(5'd3, $urandom, 1'b0);
            if (k == 3) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_early: in_ready %b required 1", in_ready); end
            end
        end
        in_enable_tag_value = {1'b1, 5'd3, 32'hDEADBEEF};
        for (int c = 0; c < 3; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_c%0d: got %b required 0", c, in_ready); end
            tick();
        end
        in_enable_tag_value = '0;
        master_ready = '1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (en_vec() !== {N{1'b1}}) begin errors++; $display("FAIL full_drain_c%0d: got %b required all ones", c, en_vec()); end
            tick();
        end
        checks++; if (en_vec() !== '0) begin errors++; $display("FAIL full_extra: got %b required 0", en_vec()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy: got %b required 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b required 1", in_ready); end
    endtask

    task automatic test_drop();
        master_ready = '1;
        push(5'd17, $urandom, 1'b0);
        wait_idle();
        checks++; if (drop_count !== m_drops) begin errors++; $display("FAIL drop_one: got %0d required %0d", drop_count, m_drops); end
        checks++; if (en_vec() !== '0) begin errors++; $display("FAIL drop_en: got %b required 0", en_vec()); end
        for (int k = 0; k < 70000; k++) push(5'd17, $urandom, 1'b0);
        wait_idle();
        checks++; if (drop_count !== m_drops) begin errors++; $display("FAIL drop_sat: got %h required %h", drop_count, m_drops); end
    endtask

    task automatic test_reset_mid();
        master_ready = '0;
        for (int k = 0; k < 4; k++) push(5'd3, $urandom, 1'b0);
        checks++; if (en_vec() !== {N{1'b1}}) begin errors++; $display("FAIL rmid_pre: got %b required all ones", en_vec()); end
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (en_vec() !== '0) begin errors++; $display("FAIL rmid_en: got %b required 0", en_vec()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
        checks++; if (id_scan_out !== 5'd0) begin errors++; $display("FAIL rmid_scan: got %0d required 0", id_scan_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b required 1", in_ready); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rmid_drop: got %0d required 0", drop_count); end
        tick();
        rst = 1'b0;
        master_ready = '1;
        push(5'd0, $urandom, 1'b0);
        tick();
        checks++; if (en_vec() !== {N{1'b1}}) begin errors++; $display("FAIL rmid_after: got %b required all ones", en_vec()); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_after_busy: got %b required 0", busy); end
    endtask

    task automatic test_random();
        logic [4:0]  tag;
        logic [31:0] val;
        logic        bc;
        int          left;
        for (int k = 0; k < N; k++) scan_id(5'($urandom_range(7)));
        for (int c = 0; c < 400; c++) begin
            master_ready = N'($urandom);
            if ($urandom_range(3) != 0 && in_ready) begin
                tag = 5'($urandom_range(7));
                val = $urandom;
                bc  = ($urandom_range(7) == 0);
                in_enable_tag_value = {1'b1, tag, val};
                in_bcast = bc;
                model_push(tag, val, bc);
            end else begin
                in_enable_tag_value = '0;
                in_bcast = 1'b0;
            end
            tick();
        end
        in_enable_tag_value = '0;
        in_bcast = 1'b0;
        master_ready = '1;
        wait_idle();
        left = 0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        checks++; if (left != 0) begin errors++; $display("FAIL rand_undelivered: %0d values still owed, required 0", left); end
        checks++; if (drop_count !== m_drops) begin errors++; $display("FAIL rand_drop: got %0d required %0d", drop_count, m_drops); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_stall();
        test_bcast();
        test_full();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
